// File: rtl/alu_sweep_ctrl_if.sv
// Host/ALU bus of the ALU operation sweeper: control, ALU drive/return and buffer read port.
// slave is the sweeper's view; master is the host/ALU side.
interface alu_sweep_ctrl_if #(
    parameter int OPW = 4,
    parameter int DW  = 32
);
    logic           start;
    logic [DW-1:0]  a_in;
    logic [DW-1:0]  b_in;
    logic [OPW-1:0] op_first;
    logic [OPW-1:0] op_last;
    logic [DW-1:0]  alu_a;
    logic [DW-1:0]  alu_b;
    logic [OPW-1:0] alu_op;
    logic [DW-1:0]  alu_result;
    logic           busy;
    logic           done;
    logic           err;
    logic [DW-1:0]  signature;
    logic [OPW-1:0] rd_addr;
    logic [DW-1:0]  rd_data;
    logic           rd_valid;

    modport slave (
        input  start, a_in, b_in, op_first, op_last, alu_result, rd_addr,
        output alu_a, alu_b, alu_op, busy, done, err, signature, rd_data, rd_valid
    );

    modport master (
        output start, a_in, b_in, op_first, op_last, alu_result, rd_addr,
        input  alu_a, alu_b, alu_op, busy, done, err, signature, rd_data, rd_valid
    );
endinterface

// File: rtl/alu_sweep_ctrl.sv
// Steps alu_op over an inclusive range with fixed operands, settling each op before
// capturing alu_result into an op-indexed buffer and a rotate-XOR signature.
module alu_sweep_ctrl #(
    parameter int SETTLE = 1,
    parameter int OPW    = 4,
    parameter int DW     = 32
) (
    input  logic               clk,
    input  logic               reset,
    alu_sweep_ctrl_if.slave    bus
);
    localparam int DEPTH = 2 ** OPW;

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_t;

    state_t          r_state;
    logic [7:0]      r_cnt;
    logic [OPW-1:0]  r_op_last;
    logic [DW-1:0]   r_alu_a;
    logic [DW-1:0]   r_alu_b;
    logic [OPW-1:0]  r_alu_op;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic [DW-1:0]   r_sig;
    logic [DW-1:0]   r_mem [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [DW-1:0]   r_rd_data;
    logic            r_rd_valid;

    // Buffer contents are deliberately left out of reset; only valid bits clear.
    always_ff @(posedge clk) begin
        if (!reset && r_state == S_SAMPLE)
            r_mem[r_alu_op] <= bus.alu_result;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_op_last  <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_sig      <= '0;
            r_valid    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_rd_data  <= r_mem[bus.rd_addr];
            r_rd_valid <= r_valid[bus.rd_addr];
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.op_first <= bus.op_last) begin
                            r_alu_a   <= bus.a_in;
                            r_alu_b   <= bus.b_in;
                            r_alu_op  <= bus.op_first;
                            r_op_last <= bus.op_last;
                            r_valid   <= '0;
                            r_sig     <= '0;
                            r_cnt     <= 8'(SETTLE - 1);
                            r_busy    <= 1'b1;
                            r_state   <= S_DRIVE;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_DRIVE: begin
                    if (r_cnt == 8'd0)
                        r_state <= S_SAMPLE;
                    else
                        r_cnt <= r_cnt - 8'd1;
                end
                S_SAMPLE: begin
                    r_valid[r_alu_op] <= 1'b1;
                    r_sig <= {r_sig[DW-2:0], r_sig[DW-1]} ^ bus.alu_result;
                    // Terminate on the latched last op so op_last=max never wraps.
                    if (r_alu_op == r_op_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_alu_op <= r_alu_op + 1'b1;
                        r_cnt    <= 8'(SETTLE - 1);
                        r_state  <= S_DRIVE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.alu_op    = r_alu_op;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.signature = r_sig;
    assign bus.rd_data   = r_rd_data;
    assign bus.rd_valid  = r_rd_valid;
endmodule

// File: tb/tb_alu_sweep_ctrl.sv
// Directed bench for alu_sweep_ctrl: ALU model result = a + b + op, two instances
// (SETTLE=1 and SETTLE=3) sharing clock and reset.
module tb_alu_sweep_ctrl;
    localparam int OPW = 4;
    localparam int DW  = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_sweep_ctrl_if #(.OPW(OPW), .DW(DW)) if1 ();
    alu_sweep_ctrl_if #(.OPW(OPW), .DW(DW)) if3 ();

    assign if1.alu_result = if1.alu_a + if1.alu_b + 32'(if1.alu_op);
    assign if3.alu_result = if3.alu_a + if3.alu_b + 32'(if3.alu_op);

    alu_sweep_ctrl #(.SETTLE(1), .OPW(OPW), .DW(DW)) u_dut1 (
        .clk(clk), .reset(reset), .bus(if1.slave));
    alu_sweep_ctrl #(.SETTLE(3), .OPW(OPW), .DW(DW)) u_dut3 (
        .clk(clk), .reset(reset), .bus(if3.slave));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sig_step(input logic [31:0] s, input logic [31:0] r);
        return {s[30:0], s[31]} ^ r;
    endfunction

    // Accept a sweep on if1 (edge 0 is the tick inside this task).
    task automatic go1(input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] f, input logic [3:0] l);
        if1.a_in = a; if1.b_in = b; if1.op_first = f; if1.op_last = l;
        if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
    endtask

    // Count edges after edge 0 until done, bounded.
    task automatic wait1(output int edges, output bit seen);
        edges = 0; seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            edges++;
            if (if1.done) seen = 1'b1;
        end
    endtask

    logic [31:0] sig;
    int e, ndone, bcnt;
    bit seen, done_any;

    initial begin
        if1.start = 0; if1.a_in = 0; if1.b_in = 0; if1.op_first = 0; if1.op_last = 0; if1.rd_addr = 0;
        if3.start = 0; if3.a_in = 0; if3.b_in = 0; if3.op_first = 0; if3.op_last = 0; if3.rd_addr = 0;

        // Reset state
        repeat (3) tick();
        chk("rst_alu_a", if1.alu_a, 0);
        chk("rst_alu_b", if1.alu_b, 0);
        chk("rst_alu_op", 32'(if1.alu_op), 0);
        chk("rst_busy", 32'(if1.busy), 0);
        chk("rst_done", 32'(if1.done), 0);
        chk("rst_err", 32'(if1.err), 0);
        chk("rst_sig", if1.signature, 0);
        chk("rst_rd_data", if1.rd_data, 0);
        chk("rst_rd_valid", 32'(if1.rd_valid), 0);
        chk("rst3_busy", 32'(if3.busy), 0);
        reset = 1'b0;
        tick();

        // Full sweep 0..13, SETTLE=1: op k held 2 cycles, done at edge 28
        go1(32'd3, 32'd5, 4'd0, 4'd13);
        chk("t1_busy", 32'(if1.busy), 1);
        chk("t1_op0", 32'(if1.alu_op), 0);
        e = 0; seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            e++;
            if (if1.done) seen = 1'b1;
            else chk($sformatf("t1_op_e%0d", e), 32'(if1.alu_op), 32'(e / 2));
        end
        sig = 0;
        for (int k = 0; k < 14; k++) sig = sig_step(sig, 32'(8 + k));
        chk("t1_done_seen", 32'(seen), 1);
        chk("t1_done_edge", 32'(e), 28);
        chk("t1_busy_done", 32'(if1.busy), 0);
        chk("t1_sig", if1.signature, sig);
        tick();
        chk("t1_done_pulse", 32'(if1.done), 0);
        chk("t1_hold_op", 32'(if1.alu_op), 13);
        chk("t1_hold_a", if1.alu_a, 3);
        for (int k = 0; k < 16; k++) begin
            if1.rd_addr = 4'(k);
            tick();
            if (k < 14) chk($sformatf("t1_mem%0d", k), if1.rd_data, 32'(8 + k));
            chk($sformatf("t1_val%0d", k), 32'(if1.rd_valid), (k < 14) ? 32'd1 : 32'd0);
        end

        // Rejected start: op_first > op_last
        go1(32'd99, 32'd99, 4'd9, 4'd2);
        chk("t3_err", 32'(if1.err), 1);
        chk("t3_busy", 32'(if1.busy), 0);
        tick();
        chk("t3_err_pulse", 32'(if1.err), 0);
        chk("t3_busy2", 32'(if1.busy), 0);
        chk("t3_sig", if1.signature, sig);
        chk("t3_alu_a", if1.alu_a, 3);
        if1.rd_addr = 4'd3;
        tick();
        chk("t3_val3", 32'(if1.rd_valid), 1);
        chk("t3_mem3", if1.rd_data, 11);

        // start spam and a_in changes mid-sweep are ignored, including in DONE
        go1(32'd1, 32'd1, 4'd0, 4'd3);
        ndone = 0; e = 0;
        for (int i = 1; i <= 20; i++) begin
            if1.start = (i <= 9);
            if1.a_in = 32'hFF00 + 32'(i);
            if1.op_first = 4'd0; if1.op_last = 4'd15;
            tick();
            if (if1.done) begin ndone++; e = i; end
            chk($sformatf("t5_alu_a_%0d", i), if1.alu_a, 1);
        end
        if1.start = 1'b0;
        chk("t5_ndone", 32'(ndone), 1);
        chk("t5_done_edge", 32'(e), 8);
        chk("t5_busy", 32'(if1.busy), 0);
        chk("t5_op", 32'(if1.alu_op), 3);
        chk("t5_sig", if1.signature, sig_step(sig_step(sig_step(sig_step(0, 2), 3), 4), 5));

        // No wrap at op 15; same-cycle read of entry 15 returns old data
        go1(32'h55, 32'd0, 4'd15, 4'd15);
        wait1(e, seen);
        chk("t6_pre_edge", 32'(e), 2);
        if1.rd_addr = 4'd15;
        tick();
        chk("t6_pre_mem15", if1.rd_data, 32'h64);
        go1(32'h100, 32'd0, 4'd12, 4'd15);
        for (int i = 1; i <= 7; i++) tick();
        tick();
        chk("t6_done", 32'(if1.done), 1);
        chk("t6_op15", 32'(if1.alu_op), 15);
        chk("t6_old_data", if1.rd_data, 32'h64);
        chk("t6_old_valid", 32'(if1.rd_valid), 0);
        tick();
        chk("t6_new_data", if1.rd_data, 32'h10F);
        chk("t6_new_valid", 32'(if1.rd_valid), 1);
        chk("t6_done_off", 32'(if1.done), 0);
        repeat (4) tick();
        chk("t6_nowrap", 32'(if1.alu_op), 15);
        chk("t6_busy", 32'(if1.busy), 0);

        // Reset at edge 7 of a sweep aborts with no done
        go1(32'd3, 32'd5, 4'd0, 4'd13);
        done_any = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (if1.done) done_any = 1'b1;
        end
        reset = 1'b1;
        tick();
        chk("t4_alu_a", if1.alu_a, 0);
        chk("t4_alu_b", if1.alu_b, 0);
        chk("t4_alu_op", 32'(if1.alu_op), 0);
        chk("t4_busy", 32'(if1.busy), 0);
        chk("t4_sig", if1.signature, 0);
        chk("t4_rd_valid", 32'(if1.rd_valid), 0);
        reset = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if1.rd_addr = 4'(k);
            tick();
            if (if1.done) done_any = 1'b1;
            chk($sformatf("t4_val%0d", k), 32'(if1.rd_valid), 0);
        end
        chk("t4_no_done", 32'(done_any), 0);
        go1(32'd7, 32'd2, 4'd0, 4'd13);
        wait1(e, seen);
        sig = 0;
        for (int k = 0; k < 14; k++) sig = sig_step(sig, 32'(9 + k));
        chk("t4_done_edge", 32'(e), 28);
        chk("t4_sig2", if1.signature, sig);
        if1.rd_addr = 4'd13;
        tick();
        chk("t4_mem13", if1.rd_data, 22);
        chk("t4_val13", 32'(if1.rd_valid), 1);
        if1.rd_addr = 4'd14;
        tick();
        chk("t4_val14", 32'(if1.rd_valid), 0);

        // SETTLE=3, single op 5: done at edge 4, busy 4 cycles
        if3.a_in = 32'h10; if3.b_in = 32'h1; if3.op_first = 4'd5; if3.op_last = 4'd5;
        if3.start = 1'b1;
        tick();
        if3.start = 1'b0;
        bcnt = if3.busy ? 1 : 0;
        e = 0; seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            tick();
            e++;
            if (if3.done) seen = 1'b1;
            if (if3.busy) bcnt++;
        end
        chk("t2_done_edge", 32'(e), 4);
        chk("t2_busy_cycles", 32'(bcnt), 4);
        chk("t2_sig", if3.signature, 32'h16);
        if3.rd_addr = 4'd5;
        tick();
        chk("t2_mem5", if3.rd_data, 32'h16);
        chk("t2_val5", 32'(if3.rd_valid), 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
